// File: rtl/freq_div_prog_if.sv
// rtl/freq_div_prog_if.sv - divisor load handshake between a programming agent and freq_div_prog.
interface freq_div_prog_if #(
    parameter int WIDTH = 8
);
    logic             div_valid;
    logic [WIDTH-1:0] div_in;
    logic             div_ready;
    logic             div_err;

    modport master (
        output div_valid,
        output div_in,
        input  div_ready,
        input  div_err
    );

    modport slave (
        input  div_valid,
        input  div_in,
        output div_ready,
        output div_err
    );
endinterface

// File: rtl/freq_div_prog.sv
// rtl/freq_div_prog.sv - programmable divider with glitch-free divisor reload at period wrap.
// Optional per-period tick output enabled by defining FREQ_DIV_TICK_EN.
module freq_div_prog #(
    parameter int WIDTH       = 8,
    parameter int DEFAULT_DIV = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    freq_div_prog_if.slave   dif,
    output logic [WIDTH-1:0] div_cur,
    output logic             clk_div
`ifdef FREQ_DIV_TICK_EN
    ,
    output logic             tick
`endif
);
    localparam logic [WIDTH-1:0] DEF_DIV = WIDTH'(DEFAULT_DIV);
    localparam logic [WIDTH-1:0] MIN_DIV = WIDTH'(2);
    localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

    typedef enum logic {ST_IDLE, ST_PEND} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] div_d;
    logic [WIDTH-1:0] pend_q, pend_d;
    logic             clk_div_d;
    logic             err_q, err_d;
    logic             wrap;
    logic             xfer;

    assign dif.div_ready = (state_q == ST_IDLE);
    assign dif.div_err   = err_q;
    assign wrap          = en && (cnt_q == div_cur - ONE);
    assign xfer          = dif.div_valid && dif.div_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            div_cur <= DEF_DIV;
            pend_q  <= '0;
            clk_div <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            div_cur <= div_d;
            pend_q  <= pend_d;
            clk_div <= clk_div_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        div_d   = div_cur;
        pend_d  = pend_q;
        err_d   = 1'b0;

        // Reload only on the wrap edge so a period is never cut short.
        if (en) begin
            if (wrap) begin
                cnt_d = '0;
                if (state_q == ST_PEND) begin
                    div_d   = pend_q;
                    state_d = ST_IDLE;
                end
            end else begin
                cnt_d = cnt_q + ONE;
            end
        end

        // xfer implies ST_IDLE, so a divisor accepted on a wrap waits for the next one.
        if (xfer) begin
            if (dif.div_in < MIN_DIV) begin
                err_d = 1'b1;
            end else begin
                pend_d  = dif.div_in;
                state_d = ST_PEND;
            end
        end

        // Registering the next-state compare keeps clk_div a pure flop output.
        clk_div_d = (cnt_d >= (div_d >> 1));
    end

`ifdef FREQ_DIV_TICK_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            tick <= 1'b0;
        end else begin
            tick <= wrap;
        end
    end
`endif

endmodule

// File: doc/freq_div_prog.md
FREQ_DIV_PROG -- requirements
Module: freq_div_prog

Interface
REQ-001 Parameter: WIDTH, default 8, bit width of divisor and counter.
REQ-002 Parameter: DEFAULT_DIV, default 6, divisor loaded at reset; legal range 2..2^WIDTH-1.
REQ-003 Port: clk  input  1  clock; all logic on rising edge.
REQ-004 Port: reset  input  1  synchronous, active-high reset.
REQ-005 Port: en  input  1  count enable; low freezes counter and outputs.
REQ-006 Port: div_valid  input  1  new divisor offered.
REQ-007 Port: div_in  input  WIDTH  offered divisor value.
REQ-008 Port: div_ready  output  1  block can accept a divisor.
REQ-009 Port: div_err  output  1  one-cycle pulse, offered divisor rejected.
REQ-010 Port: div_cur  output  WIDTH  divisor currently in effect.
REQ-011 Port: clk_div  output  1  divided clock, registered.
REQ-012 Port: tick  output  1  one-cycle pulse per period (present only with FREQ_DIV_TICK_EN).

Function
REQ-013 Counter cnt (WIDTH bits) SHALL advance 0..div_cur-1 and wrap to 0 when en=1; hold when en=0.
REQ-014 clk_div SHALL equal (cnt >= div_cur>>1) for the current cnt, driven from a flop (no combinational path from inputs).
REQ-015 Duty: even N -> N/2 low, N/2 high; odd N -> floor(N/2) low, ceil(N/2) high.
REQ-016 Handshake: transfer occurs on the cycle div_valid=1 and div_ready=1; div_in ignored otherwise.
REQ-017 Transfer with div_in<2 SHALL be rejected: div_err=1 next cycle for exactly one cycle, no state change, div_ready stays 1.
REQ-018 Transfer with div_in>=2 SHALL store it as pending; div_ready=0 from next cycle until pending applied.
REQ-019 Pending divisor SHALL apply at the wrap (cnt==div_cur-1, en=1): next cycle cnt=0, div_cur=pending, div_ready=1.
REQ-020 Transfer coinciding with a wrap SHALL be applied at the following wrap, not the current one.
REQ-021 Pending held indefinitely while en=0; div_ready remains 0.
REQ-022 div_cur SHALL never change mid-period; clk_div SHALL show no period shorter than min(old,new) half-periods.

Reset
REQ-023 On reset: cnt=0, div_cur=DEFAULT_DIV, clk_div=0, tick=0, div_err=0, div_ready=1, pending discarded.
REQ-024 Reset mid-operation SHALL override en, div_valid and any pending load in the same cycle.

Configuration
REQ-025 Macro FREQ_DIV_TICK_EN defined: tick port exists, tick=1 for one cycle in the cycle following each wrap (cnt becomes 0), 0 while en=0.
REQ-026 Macro FREQ_DIV_TICK_EN undefined: tick port and its logic absent; all other behaviour identical.

Verification
REQ-027 Reset, en=1, DEFAULT_DIV=6 -> clk_div pattern 000111 repeating; tick once per 6 cycles (macro on).
REQ-028 Load div_in=5 mid-period at cnt=2 -> div_ready low, old period completes, then clk_div 00111 repeating, div_cur=5.
REQ-029 Offer div_in=1 then div_in=0 -> div_err one-cycle pulse each, div_cur stays 6, div_ready stays 1.
REQ-030 Offer div_in=4 exactly on wrap cycle -> one more period of 6, then period 4; div_ready low throughout.
REQ-031 en=0 at cnt=3 for 10 cycles with pending div_in=8 -> cnt, clk_div frozen, tick 0, div_ready 0; resumes and applies 8 at next wrap.
REQ-032 Assert reset with pending div_in=9 at cnt=4 -> next cycle cnt=0, div_cur=6, clk_div=0, div_ready=1; 9 never applied.
